// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, CPOL/CPHA decode, word size and
// the byte engine's state type.
package spi_pkg;

  localparam int SPI_MODE0 = 0;
  localparam int SPI_MODE1 = 1;
  localparam int SPI_MODE2 = 2;
  localparam int SPI_MODE3 = 3;

  localparam int SPI_BITS  = 8;
  localparam int SPI_EDGES = 2 * SPI_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } spi_state_e;

  function automatic logic cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_edge_gen.sv
// SCLK generator for one byte transfer. A start pulse arms the half-bit
// counter. Each wrap of that counter toggles sclk. The leading/trailing
// pulses are registered alongside sclk, so each pulse is high in the same
// cycle the corresponding edge becomes visible. done_pulse coincides with
// the final (16th) edge.
module spi_edge_gen
  import spi_pkg::*;
#(
  parameter logic CPOL              = 1'b0,
  parameter int   CLKS_PER_HALF_BIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic sclk,
  output logic leading_pulse,
  output logic trailing_pulse,
  output logic done_pulse
);

  if (CLKS_PER_HALF_BIT < 2) begin : g_bad_half_bit
    $error("spi_edge_gen: CLKS_PER_HALF_BIT must be >= 2");
  end

  localparam int             HW        = $clog2(CLKS_PER_HALF_BIT);
  localparam logic [HW-1:0]  HALF_LAST = HW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [3:0]     EDGE_LAST = 4'(SPI_EDGES - 1);

  logic          active;
  logic [HW-1:0] half_cnt;
  logic [3:0]    edge_cnt;

  // Half-bit timing, edge counting and per-edge strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      active         <= 1'b0;
      half_cnt       <= '0;
      edge_cnt       <= '0;
      sclk           <= CPOL;
      leading_pulse  <= 1'b0;
      trailing_pulse <= 1'b0;
      done_pulse     <= 1'b0;
    end else begin
      leading_pulse  <= 1'b0;
      trailing_pulse <= 1'b0;
      done_pulse     <= 1'b0;
      if (start) begin
        active   <= 1'b1;
        half_cnt <= '0;
        edge_cnt <= '0;
        sclk     <= CPOL;
      end else if (active) begin
        if (half_cnt == HALF_LAST) begin
          half_cnt       <= '0;
          sclk           <= ~sclk;
          edge_cnt       <= edge_cnt + 4'd1;
          // edge_cnt holds edges already made; even count -> next is odd (leading)
          leading_pulse  <= ~edge_cnt[0];
          trailing_pulse <= edge_cnt[0];
          if (edge_cnt == EDGE_LAST) begin
            done_pulse <= 1'b1;
            active     <= 1'b0;
          end
        end else begin
          half_cnt <= half_cnt + HW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/spi_master_byte.sv
// Byte-wide SPI master: accepts a byte on tx_dv/tx_ready, shifts it out
// MSB-first on mosi while capturing miso, and returns the received byte
// with a one-cycle rx_dv. Chip select is handled upstream.
module spi_master_byte
  import spi_pkg::*;
#(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       tx_dv,
  output logic       tx_ready,
  output logic [7:0] rx_byte,
  output logic       rx_dv,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  if (SPI_MODE < SPI_MODE0 || SPI_MODE > SPI_MODE3) begin : g_bad_mode
    $error("spi_master_byte: SPI_MODE must be 0..3");
  end

  localparam logic CPOL = cpol(2'(SPI_MODE));
  localparam logic CPHA = cpha(2'(SPI_MODE));

  spi_state_e state;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [7:0] rx_next;
  logic       accept;
  logic       sample;
  logic       advance;
  logic       leading_pulse;
  logic       trailing_pulse;
  logic       done_pulse;

  spi_edge_gen #(
    .CPOL              (CPOL),
    .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
  ) u_edge_gen (
    .clk            (clk),
    .rst            (rst),
    .start          (accept),
    .sclk           (sclk),
    .leading_pulse  (leading_pulse),
    .trailing_pulse (trailing_pulse),
    .done_pulse     (done_pulse)
  );

  // Decode which edges sample miso and which advance mosi for this mode.
  always_comb begin
    accept  = tx_dv & tx_ready;
    sample  = 1'b0;
    advance = 1'b0;
    if (CPHA) begin
      sample  = trailing_pulse;
      advance = leading_pulse;
    end else begin
      sample  = leading_pulse;
      advance = trailing_pulse & ~done_pulse;
    end
    // With CPHA=1 the last sample lands in the done cycle, so rx_byte is
    // loaded from the post-sample value rather than the stale register.
    rx_next = sample ? {rx_shift[6:0], miso} : rx_shift;
  end

  // Handshake FSM plus transmit/receive shift registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx_ready <= 1'b1;
      rx_dv    <= 1'b0;
      rx_byte  <= '0;
      mosi     <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
    end else begin
      rx_dv <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (tx_dv) begin
            state    <= ST_SHIFT;
            tx_ready <= 1'b0;
            // CPHA=0 puts bit 7 out immediately, so the register keeps bit 6 next
            tx_shift <= CPHA ? tx_byte : {tx_byte[6:0], 1'b0};
            if (!CPHA) mosi <= tx_byte[7];
          end else begin
            state    <= ST_IDLE;
            tx_ready <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (advance) begin
            mosi     <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
          rx_shift <= rx_next;
          if (done_pulse) begin
            state    <= ST_DONE;
            tx_ready <= 1'b1;
            rx_dv    <= 1'b1;
            rx_byte  <= rx_next;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// Bench for spi_master_byte: four instances cover all SPI modes and several
// half-bit lengths. A behavioural slave drives miso and captures mosi at the
// SPI sample edges. Expected timing comes from closed-form cycle arithmetic.
module tb_spi_master_byte;

  localparam int NI = 4;
  localparam int MODE_OF [NI] = '{0, 1, 2, 3};
  localparam int H_OF    [NI] = '{2, 4, 5, 3};

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NI-1:0]        tx_dv, tx_ready, rx_dv, sclk, mosi, miso;
  logic [NI-1:0][7:0]   tx_byte, rx_byte;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_master_byte #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(2)) u_dut0 (
    .clk(clk), .rst(rst), .tx_byte(tx_byte[0]), .tx_dv(tx_dv[0]), .tx_ready(tx_ready[0]),
    .rx_byte(rx_byte[0]), .rx_dv(rx_dv[0]), .sclk(sclk[0]), .mosi(mosi[0]), .miso(miso[0]));
  spi_master_byte #(.SPI_MODE(1), .CLKS_PER_HALF_BIT(4)) u_dut1 (
    .clk(clk), .rst(rst), .tx_byte(tx_byte[1]), .tx_dv(tx_dv[1]), .tx_ready(tx_ready[1]),
    .rx_byte(rx_byte[1]), .rx_dv(rx_dv[1]), .sclk(sclk[1]), .mosi(mosi[1]), .miso(miso[1]));
  spi_master_byte #(.SPI_MODE(2), .CLKS_PER_HALF_BIT(5)) u_dut2 (
    .clk(clk), .rst(rst), .tx_byte(tx_byte[2]), .tx_dv(tx_dv[2]), .tx_ready(tx_ready[2]),
    .rx_byte(rx_byte[2]), .rx_dv(rx_dv[2]), .sclk(sclk[2]), .mosi(mosi[2]), .miso(miso[2]));
  spi_master_byte #(.SPI_MODE(3), .CLKS_PER_HALF_BIT(3)) u_dut3 (
    .clk(clk), .rst(rst), .tx_byte(tx_byte[3]), .tx_dv(tx_dv[3]), .tx_ready(tx_ready[3]),
    .rx_byte(rx_byte[3]), .rx_dv(rx_dv[3]), .sclk(sclk[3]), .mosi(mosi[3]), .miso(miso[3]));

  typedef struct {
    int         inst;
    logic [7:0] tx;
    logic [7:0] sl;
    bit         loop;
    int         busy_at;
    int         gap;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Slave drives miso from the number of sclk edges it has seen so far.
  task automatic drive_miso(input int i, input int edges, input logic [7:0] sl, input bit loop);
    int idx;
    if (loop) begin
      miso[i] = mosi[i];
    end else begin
      if (MODE_OF[i] % 2 == 1) idx = (edges == 0) ? 0 : (edges - 1) / 2;
      else                     idx = edges / 2;
      if (idx > 7) idx = 7;
      miso[i] = sl[7 - idx];
    end
  endtask

  // Called at a negedge with instance i idle; that cycle is the accept cycle T.
  // Returns at the negedge of the rx_dv cycle, so a following call is back-to-back.
  task automatic run_xfer(input int i, input logic [7:0] tx, input logic [7:0] sl,
                          input bit loop, input int busy_at, input logic [7:0] exp_rx,
                          input string tag);
    int         h;
    int         last;
    int         e_exp;
    int         e_obs;
    int         n_cap;
    int         sclk_err, rdy_err, dv_err;
    logic       cpol_b;
    bit         cpha_b;
    logic       prev_sclk, prev_mosi;
    logic [7:0] got_mosi;
    h        = H_OF[i];
    last     = 16 * h + 2;
    cpol_b   = 1'((MODE_OF[i] >> 1) & 1);
    cpha_b   = (MODE_OF[i] % 2) == 1;
    e_obs    = 0;
    n_cap    = 0;
    sclk_err = 0;
    rdy_err  = 0;
    dv_err   = 0;
    got_mosi = '0;
    check({tag, "_ready_T"}, 32'(tx_ready[i]), 32'd1);
    tx_dv[i]   = 1'b1;
    tx_byte[i] = tx;
    prev_sclk  = sclk[i];
    prev_mosi  = mosi[i];
    drive_miso(i, 0, sl, loop);
    for (int j = 1; j <= last; j++) begin
      @(negedge clk);
      if (j == 1) begin
        tx_dv[i]   = 1'b0;
        tx_byte[i] = ~tx;
      end
      if (busy_at != 0 && j == busy_at) begin
        tx_dv[i]   = 1'b1;
        tx_byte[i] = 8'hFF;
      end
      if (busy_at != 0 && j == busy_at + 1) tx_dv[i] = 1'b0;
      e_exp = (j - 1) / h;
      if (e_exp > 16) e_exp = 16;
      if (sclk[i] !== (cpol_b ^ e_exp[0])) sclk_err++;
      if (tx_ready[i] !== (j == last)) rdy_err++;
      if (rx_dv[i] !== (j == last)) dv_err++;
      if (sclk[i] !== prev_sclk) begin
        e_obs++;
        if ((cpha_b && e_obs % 2 == 0) || (!cpha_b && e_obs % 2 == 1)) begin
          got_mosi = {got_mosi[6:0], prev_mosi};
          n_cap++;
        end
      end
      prev_sclk = sclk[i];
      prev_mosi = mosi[i];
      if (j == last) check({tag, "_rx_byte"}, 32'(rx_byte[i]), 32'(exp_rx));
      drive_miso(i, e_obs, sl, loop);
    end
    check({tag, "_sclk_seq_errs"}, 32'(sclk_err), 32'd0);
    check({tag, "_ready_seq_errs"}, 32'(rdy_err), 32'd0);
    check({tag, "_rxdv_seq_errs"}, 32'(dv_err), 32'd0);
    check({tag, "_mosi_bits"}, {24'(n_cap), got_mosi}, {24'd8, tx});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rtx, rsl;
    bit         rloop;
    int         ri, rgap;
    int         dv_seen;

    tbl[0] = '{0, 8'hA5, 8'h3C, 1'b0, 0, 1, 8'h3C};
    tbl[1] = '{3, 8'h81, 8'hFF, 1'b0, 0, 1, 8'hFF};
    tbl[2] = '{1, 8'h5A, 8'h00, 1'b1, 0, 1, 8'h5A};
    tbl[3] = '{2, 8'h5A, 8'h00, 1'b1, 0, 1, 8'h5A};
    tbl[4] = '{0, 8'h00, 8'hC9, 1'b0, 5, 2, 8'hC9};
    tbl[5] = '{0, 8'h12, 8'h56, 1'b0, 0, 2, 8'h56};
    tbl[6] = '{0, 8'h34, 8'h78, 1'b0, 0, 0, 8'h78};
    tbl[7] = '{3, 8'h00, 8'h00, 1'b0, 0, 1, 8'h00};

    rst     = 1'b1;
    tx_dv   = '0;
    tx_byte = '0;
    miso    = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_sclk_%0d", i), 32'(sclk[i]), 32'((MODE_OF[i] >> 1) & 1));
      check($sformatf("rst_mosi_%0d", i), 32'(mosi[i]), 32'd0);
      check($sformatf("rst_ready_%0d", i), 32'(tx_ready[i]), 32'd1);
      check($sformatf("rst_rxdv_%0d", i), 32'(rx_dv[i]), 32'd0);
      check($sformatf("rst_rxbyte_%0d", i), 32'(rx_byte[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      repeat (tbl[k].gap) @(negedge clk);
      run_xfer(tbl[k].inst, tbl[k].tx, tbl[k].sl, tbl[k].loop, tbl[k].busy_at,
               tbl[k].exp_rx, $sformatf("tbl%0d", k));
    end

    // Abort by reset at T+10, then a clean transfer.
    repeat (2) @(negedge clk);
    tx_dv[0]   = 1'b1;
    tx_byte[0] = 8'h96;
    miso[0]    = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j == 1) tx_dv[0] = 1'b0;
    end
    check("abort_busy_before_rst", 32'(tx_ready[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_sclk", 32'(sclk[0]), 32'd0);
    check("abort_ready", 32'(tx_ready[0]), 32'd1);
    check("abort_mosi", 32'(mosi[0]), 32'd0);
    check("abort_rxbyte", 32'(rx_byte[0]), 32'd0);
    dv_seen = 0;
    for (int j = 0; j < 40; j++) begin
      if (rx_dv[0] !== 1'b0) dv_seen++;
      @(negedge clk);
    end
    check("abort_no_rxdv", 32'(dv_seen), 32'd0);
    run_xfer(0, 8'hC3, 8'h69, 1'b0, 0, 8'h69, "after_abort");
    repeat (3) @(negedge clk);
    check("mosi_hold_last_bit", 32'(mosi[0]), 32'd1);
    check("rxbyte_held", 32'(rx_byte[0]), 32'h69);

    // Randomized transfers against the slave model.
    for (int r = 0; r < 24; r++) begin
      ri    = $urandom_range(0, NI - 1);
      rtx   = 8'($urandom);
      rsl   = 8'($urandom);
      rloop = 1'($urandom_range(0, 1));
      rgap  = $urandom_range(0, 2);
      repeat (rgap) @(negedge clk);
      run_xfer(ri, rtx, rsl, rloop, 0, rloop ? rtx : rsl, $sformatf("rnd%0d_i%0d", r, ri));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
